// File: rtl/qam_symbol_scheduler.sv
// QAM symbol scheduler: slices accepted data words into 1/2/4-bit
// symbols, LSB first, for the qam_2 / qam_4 / qam_16 mapper bank.
module qam_symbol_scheduler #(
  parameter int DATA_W = 32,
  parameter int SYM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2:0]        qam,
  output logic [SYM_W-1:0]  m_sym,
  output logic [1:0]        m_mode,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              error
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    sym_left_q, sym_left_d;
  logic [1:0]          mode_q, mode_d;
  logic [SYM_W-1:0]    m_sym_q, m_sym_d;
  logic                m_last_q, m_last_d;
  logic                m_valid_q, m_valid_d;
  logic                error_q, error_d;

  logic                accept;
  logic                last_sym;
  logic                legal;
  logic [1:0]          new_mode;
  logic [CNT_W-1:0]    new_cnt;
  logic [DATA_W-1:0]   shifted;

  // Low bits of the word for one symbol, zero-extended to SYM_W.
  function automatic logic [SYM_W-1:0] slice(
    input logic [3:0] w,
    input logic [1:0] md
  );
    logic [SYM_W-1:0] r;
    r = '0;
    case (md)
      2'd0:    r[0]   = w[0];
      2'd1:    r[1:0] = w[1:0];
      default: r[3:0] = w;
    endcase
    return r;
  endfunction

  assign last_sym = (sym_left_q == CNT_W'(1));

  // A new word fits when idle, or when the last symbol leaves now.
  assign s_ready = (state_q == IDLE) ||
                   ((state_q == SHIFT) && m_valid_q &&
                    m_ready && last_sym);

  assign accept = s_valid && s_ready;

  // Decode requested mode into mapper select and symbol count.
  always_comb begin
    legal    = 1'b1;
    new_mode = 2'd0;
    new_cnt  = CNT_W'(DATA_W);
    case (qam)
      3'd0: begin
        new_mode = 2'd0;
        new_cnt  = CNT_W'(DATA_W);
      end
      3'd1: begin
        new_mode = 2'd1;
        new_cnt  = CNT_W'(DATA_W / 2);
      end
      3'd2: begin
        new_mode = 2'd2;
        new_cnt  = CNT_W'(DATA_W / 4);
      end
      default: legal = 1'b0;
    endcase
  end

  // Shift register advanced by the latched bits-per-symbol.
  always_comb begin
    shifted = shreg_q;
    case (mode_q)
      2'd0:    shifted = shreg_q >> 1;
      2'd1:    shifted = shreg_q >> 2;
      default: shifted = shreg_q >> 4;
    endcase
  end

  // Next-state: consume the current symbol, then maybe load a word.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    sym_left_d = sym_left_q;
    mode_d     = mode_q;
    m_sym_d    = m_sym_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q;
    error_d    = error_q;

    if ((state_q == SHIFT) && m_ready) begin
      shreg_d    = shifted;
      sym_left_d = sym_left_q - CNT_W'(1);
      m_sym_d    = slice(shifted[3:0], mode_q);
      m_last_d   = (sym_left_q == CNT_W'(2));
      if (last_sym) begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_sym_d   = '0;
      end
    end

    if (accept) begin
      if (legal) begin
        state_d    = SHIFT;
        shreg_d    = s_data;
        mode_d     = new_mode;
        sym_left_d = new_cnt;
        m_sym_d    = slice(s_data[3:0], new_mode);
        m_last_d   = (new_cnt == CNT_W'(1));
        m_valid_d  = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  // State and registered outputs; async reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      sym_left_q <= '0;
      mode_q     <= 2'd0;
      m_sym_q    <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      sym_left_q <= sym_left_d;
      mode_q     <= mode_d;
      m_sym_q    <= m_sym_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
      error_q    <= error_d;
    end
  end

  assign m_sym   = m_sym_q;
  assign m_mode  = mode_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign error   = error_q;

endmodule

// File: doc/qam_symbol_scheduler.md
Name: qam_symbol_scheduler

Overview:
- Sequences the QAM modulator datapath: accepts 32-bit data words over a valid/ready handshake and slices each word into per-symbol bit groups (1, 2 or 4 bits) for the selected QAM mapper.
- Latches the modulation mode once per word, so a `qam` change never splits a word.
- Sits between the upstream word source and the qam_2 / qam_4 / qam_16 mapper bank, and drives their select and data inputs.

Parameters:
- DATA_W, 32, input word width; must be a multiple of 4.
- SYM_W, 4, output symbol field width (maximum bits per symbol).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  DATA_W  input word.
- s_valid  in  1  input word valid.
- s_ready  out  1  scheduler can accept a word this cycle.
- qam  in  3  mode request; 0 = 2-QAM (1 bit), 1 = 4-QAM (2 bits), 2 = 16-QAM (4 bits); 3..7 illegal.
- m_sym  out  SYM_W  current symbol bits, zero-extended above bits-per-symbol.
- m_mode  out  2  latched mode of the current word (0/1/2); drives mapper select.
- m_valid  out  1  m_sym valid.
- m_ready  in  1  downstream mapper accepts the symbol.
- m_last  out  1  m_sym is the final symbol of its word.
- error  out  1  sticky illegal-mode flag.

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE.
  - m_valid=0, m_last=0, m_sym=0, m_mode=0, error=0; shift register and symbol counter cleared.
  - Reset mid-word discards the remainder of that word.
  - All outputs are registered except s_ready.
- Word accept: occurs when s_valid && s_ready. In the same edge:
  - s_data is loaded into the shift register.
  - qam is decoded into bps (1/2/4) and m_mode.
  - sym_left is loaded with DATA_W/bps (32/16/8 for DATA_W=32).
- s_ready = (state==IDLE) || (state==SHIFT && m_valid && m_ready && sym_left==1).
  - Back-to-back words therefore flow with no bubble.
  - s_ready is combinational from m_ready.
- States:
  - IDLE: m_valid=0. On accept with legal qam, go to SHIFT.
  - SHIFT: m_valid=1. On m_ready:
    - Shift the register right by bps and decrement sym_left.
    - If sym_left==1 and no new word is accepted, go to IDLE.
    - If sym_left==1 and a new word is accepted, stay in SHIFT with the new word loaded.
- Latency: first symbol appears on m_valid one cycle after the accept edge.
- Symbol order: LSB first.
  - m_sym = shift_reg[bps-1:0], zero-extended; e.g. 2-QAM gives m_sym = {3'b0, bit}.
  - m_last = (sym_left==1) while m_valid.
- Backpressure: while m_valid && !m_ready, m_sym, m_mode, m_last and the internal state hold unchanged. s_valid/s_data may change freely while s_ready=0.
- Mode changes on qam mid-word are ignored until the next accept.
- Illegal qam (3..7) at accept:
  - The word is consumed and discarded, with no symbols emitted.
  - error is set to 1 and stays set until reset.
  - State stays/returns IDLE; a legal word may be accepted the following cycle.
- Counter widths:
  - sym_left is clog2(DATA_W)+1 bits and never underflows.
  - It is reloaded only on accept.

Test Plan:
- Reset then word 0xA5A5_A5A5 with qam=1, m_ready=1 → 16 symbols 1,1,2,2,1,1,2,2,…; m_mode=1; m_last only on the 16th; first m_valid 1 cycle after accept; s_ready high on the 16th symbol cycle.
- Word 0x1234_5678 with qam=2, m_ready toggled 1/0 every cycle → m_sym sequence 8,7,6,5,4,3,2,1, each held stable while m_ready=0; 8 symbols over 15 cycles.
- Two consecutive words, 0xFFFF_FFFF with qam=0 then 0x0000_0000 with qam=2, s_valid held high → 32 symbols of 1 followed immediately by 8 symbols of 0, with no idle cycle; m_mode switches 0→2 exactly at the first symbol of word 2.
- qam changed from 0 to 1 at symbol 5 of a qam=0 word → all 32 symbols remain 1-bit with m_mode=0; the next word uses mode 1.
- Word accepted with qam=5 → no m_valid, error=1 the next cycle and held; a following legal word (qam=0, 0x1) emits 32 symbols normally while error stays 1.
- rst asserted low for one cycle at symbol 10 of a qam=1 word → m_valid=0 and error=0 immediately (async); s_ready=1 after release; the next word starts from symbol 0.
